// File: rtl/alu_mdu_if.sv
// Request/response bundle for the ALU/multiply-divide unit.
interface alu_mdu_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [4:0]      op_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            sign_o;
    logic            busy_o;

    modport slave (
        input  in_valid_i, op_i, data1_i, data2_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, sign_o, busy_o
    );

    modport master (
        output in_valid_i, op_i, data1_i, data2_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, sign_o, busy_o
    );
endinterface

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus iterative shift-add multiplier and restoring divider.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | multiply/divide iterating, one bit per cycle
// DONE  | result presented until the consumer takes it
module alu_mdu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input logic    clk_i,
    input logic    rst_i,
    alu_mdu_if.slave bus
);
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] result_q;
    logic [4:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;

    // request decode
    logic            accept, is_mul, is_div, div_zero, div_ovf, go_busy;
    logic            a_neg, b_neg, a_signed, b_signed;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [SHAMT_W-1:0] shamt;

    assign accept   = bus.in_valid_i && (state == IDLE) && !bus.flush_i;
    assign is_mul   = (bus.op_i[4:2] == 3'b100);
    assign is_div   = (bus.op_i[4:2] == 3'b101);
    assign div_zero = is_div && (bus.data2_i == '0);
    assign div_ovf  = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                      (bus.data1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.data2_i == '1);
    assign go_busy  = (is_mul || is_div) && !div_zero && !div_ovf;
    assign shamt    = bus.data2_i[SHAMT_W-1:0];

    assign a_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                      (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
    assign b_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    assign a_neg    = a_signed && bus.data1_i[XLEN-1];
    assign b_neg    = b_signed && bus.data2_i[XLEN-1];
    assign a_mag    = a_neg ? -bus.data1_i : bus.data1_i;
    assign b_mag    = b_neg ? -bus.data2_i : bus.data2_i;

    // single-cycle results, including the divide fast paths
    always_comb begin
        fast_res = bus.data1_i;
        case (bus.op_i)
            OP_ADD:  fast_res = bus.data1_i + bus.data2_i;
            OP_SUB:  fast_res = bus.data1_i - bus.data2_i;
            OP_AND:  fast_res = bus.data1_i & bus.data2_i;
            OP_OR:   fast_res = bus.data1_i | bus.data2_i;
            OP_XOR:  fast_res = bus.data1_i ^ bus.data2_i;
            OP_SLL:  fast_res = bus.data1_i << shamt;
            OP_SRL:  fast_res = bus.data1_i >> shamt;
            OP_SRA:  fast_res = $signed(bus.data1_i) >>> shamt;
            OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(bus.data1_i) < $signed(bus.data2_i)};
            OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, bus.data1_i < bus.data2_i};
            OP_DIV:  fast_res = div_zero ? '1 : bus.data1_i;
            OP_DIVU: fast_res = '1;
            OP_REM:  fast_res = div_zero ? bus.data1_i : '0;
            OP_REMU: fast_res = bus.data1_i;
            default: fast_res = bus.data1_i;
        endcase
    end

    // one iteration step; multiply shifts right through {hi,lo}, divide shifts left
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ok, op_q_mul;
    logic [XLEN-1:0]   hi_nxt, lo_nxt, div_val, div_fix;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   final_res;

    assign op_q_mul  = (op_q[4:2] == 3'b100);
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ok    = !div_diff[XLEN];
    assign hi_nxt    = op_q_mul ? mul_sum[XLEN:1]
                                : (div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]);
    assign lo_nxt    = op_q_mul ? {mul_sum[0], lo_q[XLEN-1:1]} : {lo_q[XLEN-2:0], div_ok};
    assign prod      = {hi_nxt, lo_nxt};
    assign prod_fix  = neg_q ? -prod : prod;
    assign div_val   = op_q[1] ? hi_nxt : lo_nxt;
    assign div_fix   = neg_q ? -div_val : div_val;
    assign final_res = op_q_mul ? ((op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN])
                                : div_fix;

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state: flush overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = go_busy ? BUSY : DONE;
            BUSY: if (cnt == '0) state_nxt = DONE;
            DONE: if (bus.out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush_i) state_nxt = IDLE;
    end

    // operand capture, iteration and result register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
        end else if (bus.flush_i) begin
            cnt <= '0;
        end else if (accept) begin
            op_q  <= bus.op_i;
            neg_q <= (bus.op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
            hi_q  <= '0;
            lo_q  <= a_mag;
            b_q   <= b_mag;
            if (go_busy) cnt <= CNT_W'(XLEN-1);
            else         result_q <= fast_res;
        end else if (state == BUSY) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (cnt == '0) result_q <= final_res;
            else           cnt <= cnt - CNT_W'(1);
        end
    end

    assign bus.in_ready_o  = (state == IDLE);
    assign bus.out_valid_o = (state == DONE);
    assign bus.busy_o      = (state == BUSY);
    assign bus.result_o    = result_q;
    assign bus.zero_o      = (result_q == '0);
    assign bus.sign_o      = result_q[XLEN-1];
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed vector table, random ops against a reference model,
// and hand sequences for backpressure, flush and asynchronous reset.
module tb_alu_mdu;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_if #(.XLEN(XLEN)) bus();
    alu_mdu #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // reference model: plain 64-bit arithmetic on the operand values
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] up;
        int          sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  begin p = longint'(a) * (longint'(1) << sh); return p[31:0]; end
            5'd6:  begin p = longint'(a) / (longint'(1) << sh); return p[31:0]; end
            5'd7:  begin
                       // floor division by 2^sh gives the sign-filled shift
                       p = sa / (longint'(1) << sh);
                       if (sa < 0 && (sa % (longint'(1) << sh)) != 0) p = p - 1;
                       return p[31:0];
                   end
            5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd16: begin p = sa * sb; return p[31:0]; end
            5'd17: begin p = sa * sb; return p[63:32]; end
            5'd18: begin p = sa * longint'(b); return p[63:32]; end
            5'd19: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            5'd20: begin
                       if (b == 0) return 32'hFFFF_FFFF;
                       if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                       p = sa / sb; return p[31:0];
                   end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                       if (b == 0) return a;
                       if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                       p = sa % sb; return p[31:0];
                   end
            5'd23: return (b == 0) ? a : a % b;
            default: return a;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 5'd16 && op <= 5'd19) return 33;
        if (op >= 5'd20 && op <= 5'd23) begin
            if (b == 0) return 1;
            if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    // call at a negedge with the unit idle; returns at the negedge where out_valid is seen
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.data1_i    = a;
        bus.data2_i    = b;
        @(posedge clk);
        lat      = 1;
        busy_cnt = 0;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.op_i       = 5'($urandom);
        bus.data1_i    = $urandom;
        bus.data2_i    = $urandom;
        while (!bus.out_valid_o && lat < 100) begin
            if (bus.busy_o) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = bus.result_o;
    endtask

    task automatic release_done();
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
    endtask

    task automatic do_and_check(input string tag, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int lat, busy_cnt;
        run_op(op, a, b, res, lat, busy_cnt);
        check($sformatf("%s result op=%0d a=%h b=%h", tag, op, a, b), res, exp_res);
        check($sformatf("%s latency op=%0d", tag, op), lat, exp_lat);
        check($sformatf("%s busy cycles op=%0d", tag, op), busy_cnt, exp_lat - 1);
        check($sformatf("%s flags op=%0d", tag, op), {bus.zero_o, bus.sign_o, bus.in_ready_o},
              {exp_res == 0, exp_res[31], 1'b0});
        release_done();
    endtask

    vec_t vecs[$];
    logic [4:0]  op_list[20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                                 5'd13, 5'd27};
    logic [31:0] specials[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin : main
        logic [31:0] res, held, a, b;
        logic [4:0]  op;
        int lat, busy_cnt;
        logic ok;

        bus.in_valid_i  = 1'b0;
        bus.op_i        = '0;
        bus.data1_i     = '0;
        bus.data2_i     = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("reset in_ready", bus.in_ready_o, 1);
        check("reset out_valid", bus.out_valid_o, 0);
        check("reset busy", bus.busy_o, 0);
        check("reset result", bus.result_o, 0);
        check("reset zero/sign", {bus.zero_o, bus.sign_o}, 2'b10);

        vecs.push_back('{5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1});
        vecs.push_back('{5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1});
        vecs.push_back('{5'd9,  32'h1,         32'hFFFF_FFFF, 32'h1,         1});
        vecs.push_back('{5'd8,  32'h1,         32'hFFFF_FFFF, 32'h0,         1});
        vecs.push_back('{5'd1,  32'h0,         32'h1,         32'hFFFF_FFFF, 1});
        vecs.push_back('{5'd5,  32'h1,         32'h21,        32'h2,         1});
        vecs.push_back('{5'd12, 32'h1234,      32'h55,        32'h1234,      1});
        vecs.push_back('{5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         33});
        vecs.push_back('{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33});
        vecs.push_back('{5'd18, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{5'd20, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{5'd22, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{5'd21, 32'h7,         32'h2,         32'h3,         33});
        vecs.push_back('{5'd21, 32'h5,         32'h0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1});
        vecs.push_back('{5'd23, 32'h5,         32'h0,         32'h5,         1});

        // first vector is driven as reset drops, so it is taken on the first edge after reset
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++)
            do_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                         vecs[i].res, vecs[i].lat);

        for (int i = 0; i < 60; i++) begin
            op = op_list[$urandom_range(0, 19)];
            a  = pick_operand();
            b  = pick_operand();
            do_and_check($sformatf("rnd%0d", i), op, a, b, ref_result(op, a, b), ref_lat(op, a, b));
        end

        // backpressure: result held, no new request taken, even in the release cycle
        run_op(5'd0, 32'd3, 32'd4, held, lat, busy_cnt);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid_i = 1'b1;
            bus.op_i       = 5'd1;
            bus.data1_i    = $urandom;
            bus.data2_i    = $urandom;
            @(posedge clk);
            @(negedge clk);
            if (bus.result_o !== 32'd7 || !bus.out_valid_o || bus.in_ready_o) ok = 1'b0;
        end
        check("backpressure hold", ok, 1);
        release_done();
        check("no accept on release edge", {bus.in_ready_o, bus.out_valid_o}, 2'b10);
        bus.in_valid_i = 1'b0;

        // flush while idle wins over a valid request
        bus.in_valid_i = 1'b1;
        bus.flush_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        check("flush beats accept", {bus.in_ready_o, bus.busy_o, bus.out_valid_o}, 3'b100);

        // flush in the fifth busy cycle
        bus.in_valid_i = 1'b1;
        bus.op_i       = 5'd16;
        bus.data1_i    = 32'd3;
        bus.data2_i    = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        check("busy before flush", bus.busy_o, 1);
        bus.flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush to idle", {bus.in_ready_o, bus.busy_o, bus.out_valid_o}, 3'b100);
        check("flush keeps result", bus.result_o, 32'd7);
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid_o) ok = 1'b0;
        end
        check("no result after flush", ok, 1);
        do_and_check("post-flush", 5'd16, 32'd3, 32'd5, 32'd15, 33);

        // asynchronous reset in the middle of a divide
        bus.in_valid_i = 1'b1;
        bus.op_i       = 5'd21;
        bus.data1_i    = 32'd100;
        bus.data2_i    = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #1 rst = 1'b1;
        #1;
        check("async reset state", {bus.in_ready_o, bus.busy_o, bus.out_valid_o}, 3'b100);
        check("async reset result", bus.result_o, 32'd0);
        check("async reset flags", {bus.zero_o, bus.sign_o}, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid_o) ok = 1'b0;
        end
        check("no result after reset", ok, 1);
        do_and_check("post-reset", 5'd23, 32'd100, 32'd7, 32'd2, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; legal values 16, 32, 64.
REQ-002 Parameter: SHAMT_W, default $clog2(XLEN), number of shift-amount bits taken from operand 2.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 in_valid_i  input  1  operation request valid.
REQ-006 in_ready_o  output  1  block can accept a request.
REQ-007 op_i  input  5  operation code (REQ-013).
REQ-008 data1_i, data2_i  input  XLEN each  operands 1 and 2.
REQ-009 flush_i  input  1  abort any in-flight operation.
REQ-010 out_valid_o  output  1  result valid.
REQ-011 out_ready_i  input  1  consumer accepts the result.
REQ-012 result_o (XLEN), zero_o (1), sign_o (1), busy_o (1)  outputs
- zero_o: result_o == 0.
- sign_o: result_o[XLEN-1].
- busy_o: state BUSY.

Function
REQ-013 Op codes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Any other code: result = data1_i.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready_o = (state == IDLE); out_valid_o = (state == DONE).
REQ-015 Accept: request accepted on a cycle where in_valid_i && in_ready_o; op and operands registered at that edge.
REQ-016 Ops 0-9 and undefined codes: IDLE -> DONE, result registered at the accept edge; latency 1.
REQ-017 Shifts use data2_i[SHAMT_W-1:0] only; SRA sign-fills; SLT signed compare, SLTU unsigned; compare result zero-extended 0/1.
REQ-018 ADD/SUB wrap modulo 2^XLEN; no overflow flag.
REQ-019 Multiply ops: IDLE -> BUSY; iterative shift-add of operand magnitudes, one bit per cycle, XLEN BUSY cycles, then DONE; total latency XLEN+1.
- MUL returns the low XLEN bits of the 2*XLEN product.
- MULH, MULHSU, MULHU return the high XLEN bits with signed x signed, signed x unsigned, unsigned x unsigned operands respectively.
REQ-020 Divide ops: iterative restoring division, one quotient bit per cycle, XLEN BUSY cycles, latency XLEN+1.
- Signed ops divide magnitudes, then quotient sign = sign1 XOR sign2, remainder sign = sign of dividend.
REQ-021 Divide by zero fast path: IDLE -> DONE directly, latency 1.
- DIV/DIVU return all ones.
- REM/REMU return data1_i.
REQ-022 Signed overflow fast path (data1_i = most-negative, data2_i = -1): IDLE -> DONE, latency 1.
- DIV returns data1_i.
- REM returns 0.
REQ-023 Iteration counter: SHAMT_W+1 bits, loaded with XLEN-1 on entering BUSY, decremented each BUSY cycle; BUSY -> DONE when it reaches 0.
REQ-024 DONE: result_o, zero_o and sign_o held stable until out_ready_i is sampled high; then DONE -> IDLE. No new request accepted in that same cycle.
REQ-025 zero_o and sign_o are derived from the registered result_o only.
REQ-026 flush_i high at an edge: state -> IDLE and counter cleared from any state; result_o retained; flush_i has priority over accept and over out_ready_i.
REQ-027 Inputs are not sampled while BUSY or DONE; operand changes there have no effect.

Reset
REQ-028 rst_i high: immediately, without waiting for a clock edge, state = IDLE, counter = 0, result_o = 0, out_valid_o = 0, busy_o = 0, in_ready_o = 1, zero_o = 1, sign_o = 0.
REQ-029 rst_i asserted during BUSY abandons the operation; no result is ever presented for it.
REQ-030 First accept is possible on the first rising edge after rst_i deasserts.

Verification (XLEN = 32)
REQ-031 ADD 0x7FFFFFFF + 1 -> one cycle later: out_valid_o = 1, result_o = 0x80000000, sign_o = 1, zero_o = 0.
REQ-032 SRA 0x80000000 by data2_i = 0x00000024 (shamt 4) -> result_o = 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> result_o = 1.
REQ-033 MULH 0xFFFFFFFF x 0xFFFFFFFF -> busy_o high 32 cycles, out_valid_o at cycle 33, result_o = 0; MULHU on the same operands -> result_o = 0xFFFFFFFE.
REQ-034 DIV -7 / 2 -> result_o = 0xFFFFFFFD after 33 cycles; REM -7 / 2 -> result_o = 0xFFFFFFFF.
REQ-035 DIVU 5 / 0 -> result_o = 0xFFFFFFFF after 1 cycle; DIV 0x80000000 / 0xFFFFFFFF -> result_o = 0x80000000 after 1 cycle.
REQ-036 Backpressure, flush and reset:
- Hold out_ready_i = 0 for 10 cycles: result_o stable, in_ready_o = 0.
- flush_i at BUSY cycle 5: IDLE next cycle, no out_valid_o.
- rst_i mid-BUSY: outputs take their reset values immediately.
